// File: rtl/uart_io_ctrl.sv
// UART bus-side controller: register decode, FIFO push/pop sequencing,
// baud tick generation and the TX FIFO-to-transmitter scheduler.
module uart_io_ctrl #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           IO_SELECT   = 4,
    parameter logic [IO_SELECT-1:0]  UART_SELECT = 4'b0001,
    parameter int unsigned           DIV_WIDTH   = 16,
    parameter int unsigned           DEFAULT_DIV = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic                  req_valid,
    output logic                  data_valid,
    output logic                  tx_push,
    output logic [7:0]            tx_wdata,
    input  logic                  tx_full,
    input  logic                  tx_empty,
    output logic                  tx_pop,
    output logic                  tx_start,
    input  logic                  tx_done,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  rx_push,
    output logic                  rx_pop,
    input  logic [7:0]            rx_rdata,
    input  logic                  rx_full,
    input  logic                  rx_empty,
    output logic                  baud_tick
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic       {B_IDLE, B_RESP} bus_state_e;
    typedef enum logic [1:0] {T_IDLE, T_POP, T_LOAD, T_WAIT} tx_state_e;

    bus_state_e            bus_q, bus_d;
    tx_state_e             tx_q, tx_d;
    logic                  data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_val;
    logic                  tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic                  overrun_q, overrun_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  new_div, reload_cur, reload_new;

    logic       sel, accept, ctrl_wr, stat_clr, run;
    logic [1:0] reg_sel;
    logic       unused_ok;

    assign reg_sel = addr[3:2];
    assign sel     = req_valid && (addr[ADDR_WIDTH-1 -: IO_SELECT] == UART_SELECT);
    // A TXDATA write stalls (is simply not accepted) while the TX FIFO is full.
    assign accept  = sel && (bus_q == B_IDLE) && !(we && (reg_sel == 2'd0) && tx_full);

    assign ctrl_wr  = accept && we && (reg_sel == 2'd3);
    assign stat_clr = accept && we && (reg_sel == 2'd2) && wdata[4];

    // Pulses are gated by reset so they drop the moment reset asserts.
    assign tx_push  = !reset && accept && we && (reg_sel == 2'd0);
    assign tx_wdata = wdata[7:0];
    assign rx_pop   = !reset && accept && !we && (reg_sel == 2'd1) && !rx_empty;
    assign rx_push  = !reset && rx_valid && rx_en_q && !rx_full;
    assign tx_pop   = (tx_q == T_POP);
    assign tx_start = (tx_q == T_LOAD);

    assign run        = tx_en_q || rx_en_q;
    assign baud_tick  = run && (cnt_q == '0);
    assign new_div    = wdata[16 +: DIV_WIDTH];
    assign reload_cur = (div_q == '0)   ? '0 : div_q - DIV_WIDTH'(1);
    assign reload_new = (new_div == '0) ? '0 : new_div - DIV_WIDTH'(1);

    assign rdata      = rdata_q;
    assign data_valid = data_valid_q;
    assign unused_ok  = ^{addr[ADDR_WIDTH-IO_SELECT-1:4], addr[1:0], wdata[15:8], rx_byte};

    // Read mux
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            2'd1:    rd_val = rx_empty ? '0 : DATA_WIDTH'(rx_rdata);
            2'd2:    rd_val = DATA_WIDTH'({(tx_q != T_IDLE), overrun_q, rx_full,
                                           rx_empty, tx_empty, tx_full});
            2'd3:    rd_val = DATA_WIDTH'({div_q, 14'b0, rx_en_q, tx_en_q});
            default: rd_val = '0;
        endcase
    end

    // Bus FSM and register updates
    always_comb begin
        bus_d        = bus_q;
        data_valid_d = 1'b0;
        rdata_d      = '0;
        tx_en_d      = tx_en_q;
        rx_en_d      = rx_en_q;
        div_d        = div_q;
        overrun_d    = overrun_q;
        case (bus_q)
            B_IDLE: begin
                if (accept) begin
                    bus_d        = B_RESP;
                    data_valid_d = 1'b1;
                    if (!we) rdata_d = rd_val;
                end
            end
            default: bus_d = B_IDLE;
        endcase
        if (ctrl_wr) begin
            tx_en_d = wdata[0];
            rx_en_d = wdata[1];
            div_d   = new_div;
        end
        if (stat_clr) overrun_d = 1'b0;
        if (rx_valid && rx_en_q && rx_full) overrun_d = 1'b1;
    end

    // Baud down-counter
    always_comb begin
        cnt_d = cnt_q;
        if (ctrl_wr)              cnt_d = reload_new;
        else if (!run)            cnt_d = reload_cur;
        else if (cnt_q == '0)     cnt_d = reload_cur;
        else                      cnt_d = cnt_q - DIV_WIDTH'(1);
    end

    // TX sequencer
    always_comb begin
        tx_d = tx_q;
        case (tx_q)
            T_IDLE:  if (tx_en_q && !tx_empty) tx_d = T_POP;
            T_POP:   tx_d = T_LOAD;
            T_LOAD:  tx_d = T_WAIT;
            T_WAIT:  if (tx_done) tx_d = T_IDLE;
            default: tx_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q        <= B_IDLE;
            tx_q         <= T_IDLE;
            data_valid_q <= 1'b0;
            rdata_q      <= '0;
            tx_en_q      <= 1'b0;
            rx_en_q      <= 1'b0;
            overrun_q    <= 1'b0;
            div_q        <= DEF_DIV;
            cnt_q        <= DEF_DIV - DIV_WIDTH'(1);
        end else begin
            bus_q        <= bus_d;
            tx_q         <= tx_d;
            data_valid_q <= data_valid_d;
            rdata_q      <= rdata_d;
            tx_en_q      <= tx_en_d;
            rx_en_q      <= rx_en_d;
            overrun_q    <= overrun_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: stimulus queues expected read data,
// a negedge monitor compares every data_valid response.
module tb_uart_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, req_valid, data_valid;
    logic        tx_push, tx_full, tx_empty, tx_pop, tx_start, tx_done;
    logic [7:0]  tx_wdata, rx_byte, rx_rdata;
    logic        rx_valid, rx_push, rx_pop, rx_full, rx_empty, baud_tick;

    int checks   = 0;
    int failures = 0;
    int tx_push_cnt = 0, rx_pop_cnt = 0, tick_cnt = 0;
    logic [7:0]  last_txw = 8'h00;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_io_ctrl dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(rdata),
        .we(we), .req_valid(req_valid), .data_valid(data_valid),
        .tx_push(tx_push), .tx_wdata(tx_wdata), .tx_full(tx_full),
        .tx_empty(tx_empty), .tx_pop(tx_pop), .tx_start(tx_start),
        .tx_done(tx_done), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .rx_push(rx_push), .rx_pop(rx_pop), .rx_rdata(rx_rdata),
        .rx_full(rx_full), .rx_empty(rx_empty), .baud_tick(baud_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor and pulse counters
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                if (exp_q.size() == 0) check("unexpected_response", 32'h1, 32'h0);
                else check("rdata", rdata, exp_q.pop_front());
            end
            if (tx_push) begin tx_push_cnt++; last_txw = tx_wdata; end
            if (rx_pop) rx_pop_cnt++;
            if (baud_tick) tick_cnt++;
        end
    end

    task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] wd,
                       input logic [31:0] exp, output int lat);
        bit got = 0;
        lat = 0;
        exp_q.push_back(exp);
        addr = {4'b0001, 24'h0, r, 2'b00};
        we = w; wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (data_valid) begin got = 1; lat = i + 1; end
        end
        req_valid = 1'b0; we = 1'b0;
        if (!got) begin
            check("bus_timeout", 32'h0, 32'h1);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic rx_pulse(input logic [7:0] b, input logic exp_push);
        rx_byte = b; rx_valid = 1'b1; #1;
        check("rx_push", 32'(rx_push), 32'(exp_push));
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, p0;
        bit seen;
        reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; req_valid = 1'b0;
        tx_full = 1'b0; tx_empty = 1'b1; tx_done = 1'b0;
        rx_valid = 1'b0; rx_byte = 8'h00; rx_rdata = 8'h00;
        rx_full = 1'b0; rx_empty = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulses", 32'({tx_pop, tx_start, baud_tick, tx_push, rx_push, rx_pop}), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        bus(1'b0, 2'd3, 32'h0, 32'h01B2_0000, lat);
        check("ctrl_read_latency", 32'(lat), 32'd1);
        bus(1'b0, 2'd2, 32'h0, 32'h0000_0006, lat);

        // Baud divisor 4, then 0, then enables off
        bus(1'b1, 2'd3, 32'h0004_0003, 32'h0, lat);
        bus(1'b0, 2'd3, 32'h0, 32'h0004_0003, lat);
        t0 = tick_cnt; repeat (40) @(posedge clk); #1;
        check("ticks_div4", 32'(tick_cnt - t0), 32'd10);
        bus(1'b1, 2'd3, 32'h0000_0003, 32'h0, lat);
        t0 = tick_cnt; repeat (20) @(posedge clk); #1;
        check("ticks_div0", 32'(tick_cnt - t0), 32'd20);
        bus(1'b1, 2'd3, 32'h0000_0000, 32'h0, lat);
        t0 = tick_cnt; repeat (20) @(posedge clk); #1;
        check("ticks_disabled", 32'(tick_cnt - t0), 32'd0);

        // rx_valid ignored while rx_en=0, even with RX FIFO full
        rx_full = 1'b1;
        rx_pulse(8'h33, 1'b0);
        rx_full = 1'b0;
        bus(1'b0, 2'd2, 32'h0, 32'h0000_0006, lat);

        // TX byte through the sequencer
        bus(1'b1, 2'd3, 32'h0004_0001, 32'h0, lat);
        p0 = tx_push_cnt;
        bus(1'b1, 2'd0, 32'h0000_0041, 32'h0, lat);
        check("tx_push_cnt", 32'(tx_push_cnt - p0), 32'd1);
        check("tx_wdata", 32'(last_txw), 32'h41);
        tx_empty = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (tx_pop) seen = 1;
        end
        check("tx_pop_seen", 32'(seen), 32'h1);
        tx_empty = 1'b1;
        @(posedge clk); #1;
        check("tx_start_after_pop", 32'({tx_start, tx_pop}), 32'b10);
        @(posedge clk); #1;
        check("tx_start_one_cycle", 32'(tx_start), 32'h0);
        bus(1'b0, 2'd2, 32'h0, 32'h0000_0026, lat);
        tx_done = 1'b1; @(posedge clk); #1; tx_done = 1'b0;
        bus(1'b0, 2'd2, 32'h0, 32'h0000_0006, lat);

        // TXDATA write stalled by tx_full
        tx_full = 1'b1;
        p0 = tx_push_cnt;
        fork
            bus(1'b1, 2'd0, 32'h0000_0077, 32'h0, lat);
            begin
                repeat (5) @(posedge clk); #1;
                check("stall_no_valid", 32'(data_valid), 32'h0);
                check("stall_no_push", 32'(tx_push_cnt - p0), 32'd0);
                tx_full = 1'b0;
            end
        join
        check("stall_lat", 32'(lat), 32'd6);
        check("stall_push", 32'(tx_push_cnt - p0), 32'd1);
        check("stall_wdata", 32'(last_txw), 32'h77);

        // RX path
        bus(1'b1, 2'd3, 32'h0004_0002, 32'h0, lat);
        rx_pulse(8'h5A, 1'b1);
        rx_empty = 1'b0; rx_rdata = 8'h5A;
        p0 = rx_pop_cnt;
        bus(1'b0, 2'd1, 32'h0, 32'h0000_005A, lat);
        check("rx_pop_cnt", 32'(rx_pop_cnt - p0), 32'd1);
        rx_empty = 1'b1;
        bus(1'b0, 2'd1, 32'h0, 32'h0, lat);
        check("rx_no_pop_empty", 32'(rx_pop_cnt - p0), 32'd1);

        // Overrun set and cleared
        rx_full = 1'b1; rx_empty = 1'b0;
        rx_pulse(8'hC3, 1'b0);
        bus(1'b0, 2'd2, 32'h0, 32'h0000_001A, lat);
        bus(1'b1, 2'd2, 32'h0000_0010, 32'h0, lat);
        bus(1'b0, 2'd2, 32'h0, 32'h0000_000A, lat);
        rx_full = 1'b0; rx_empty = 1'b1;

        // Reset while the sequencer waits on tx_done
        bus(1'b1, 2'd3, 32'h0004_0001, 32'h0, lat);
        tx_empty = 1'b0;
        @(posedge clk); #1;
        tx_empty = 1'b1;
        repeat (3) @(posedge clk); #1;
        addr = {4'b0001, 28'h0}; we = 1'b1; wdata = 32'h55; req_valid = 1'b1;
        reset = 1'b1; #1;
        check("reset_pulses", 32'({tx_pop, tx_start, baud_tick, tx_push, data_valid}), 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; we = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        bus(1'b0, 2'd2, 32'h0, 32'h0000_0006, lat);
        bus(1'b0, 2'd3, 32'h0, 32'h01B2_0000, lat);

        repeat (2) @(posedge clk); #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
